adc_spi_capture: RTL

ADC_SPI_CAPTURE -- requirements
Module: adc_spi_capture

---
 rtl/adc_spi_capture.sv | 126 ++++++++++++
 1 files changed

// File: rtl/adc_spi_capture.sv
// rtl/adc_spi_capture.sv - multi-channel SPI ADC frame capture with single-shot and continuous modes
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   single-shot conversion request (honoured only when idle)
//   cont_en    in   continuous conversion enable
//   sdo        in   [NUM_CH] serial data, one line per ADC
//   cs_n       out  shared chip select, active low
//   sck        out  shared serial clock, idles high
//   data       out  [NUM_CH*DATA_W] results, channel c at [c*DATA_W +: DATA_W]
//   data_valid out  one-cycle pulse when data updates
//   busy       out  high whenever not idle
//   overrun    out  one-cycle pulse for a dropped start
module adc_spi_capture #(
    parameter int NUM_CH    = 1,
    parameter int DATA_W    = 12,
    parameter int FRAME_LEN = 16,
    parameter int LEAD_BITS = 2,
    parameter int CLK_DIV   = 1,
    parameter int QUIET_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       cont_en,
    input  logic [NUM_CH-1:0]          sdo,
    output logic                       cs_n,
    output logic                       sck,
    output logic [NUM_CH*DATA_W-1:0]   data,
    output logic                       data_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int BIT_W = $clog2(FRAME_LEN + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int QC_W  = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        QUIET = 2'd2
    } state_t;

    state_t                     state;
    state_t                     state_d;
    logic [DIV_W-1:0]           div_cnt;
    logic [BIT_W-1:0]           bit_cnt;
    logic [QC_W-1:0]            q_cnt;
    logic [NUM_CH*DATA_W-1:0]   shreg;
    logic                       sck_q;
    logic                       toggle;
    logic                       fall;
    logic                       frame_end;
    logic                       quiet_end;
    logic                       capture;

    always_comb begin
        toggle    = (state == FRAME) && (div_cnt == DIV_W'(CLK_DIV - 1));
        fall      = toggle && sck_q;
        // After the last falling edge bit_cnt equals FRAME_LEN; the rising
        // toggle that follows closes the frame so it ends with sck high.
        frame_end = toggle && !sck_q && (bit_cnt == BIT_W'(FRAME_LEN));
        quiet_end = (state == QUIET) && (q_cnt == QC_W'(QUIET_CYC - 1));
        capture   = fall && (bit_cnt >= BIT_W'(LEAD_BITS))
                         && (bit_cnt <  BIT_W'(LEAD_BITS + DATA_W));

        state_d = state;
        case (state)
            IDLE:    if (start || cont_en) state_d = FRAME;
            FRAME:   if (frame_end)        state_d = QUIET;
            QUIET:   if (quiet_end)        state_d = cont_en ? FRAME : IDLE;
            default:                       state_d = IDLE;
        endcase

        cs_n = (state != FRAME);
        busy = (state != IDLE);
        sck  = sck_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sck_q      <= 1'b1;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            q_cnt      <= '0;
            shreg      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_d;
            data_valid <= frame_end;
            // A start seen outside IDLE is dropped unless continuous mode
            // already keeps the converter running.
            overrun    <= start && !cont_en && (state != IDLE);

            if (frame_end) data <= shreg;

            // Counters sit at zero outside FRAME so every frame starts clean.
            if (state != FRAME) begin
                sck_q   <= 1'b1;
                div_cnt <= '0;
                bit_cnt <= '0;
            end else if (toggle) begin
                sck_q   <= ~sck_q;
                div_cnt <= '0;
                if (sck_q) bit_cnt <= bit_cnt + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if ((state == QUIET) && !quiet_end) q_cnt <= q_cnt + 1'b1;
            else                                q_cnt <= '0;

            if (capture) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    shreg[c*DATA_W +: DATA_W] <= {shreg[c*DATA_W +: DATA_W-1], sdo[c]};
                end
            end
        end
    end

endmodule
